// File: rtl/qram_arbiter_if.sv
// Requester and qram port bundle for qram_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the clients and the memory.
interface qram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ*DW-1:0] rsp_rdata;
  logic [AW-1:0]         mem_addr_1;
  logic [AW-1:0]         mem_addr_2;
  logic [AW-1:0]         mem_addr_3;
  logic [AW-1:0]         mem_addr_4;
  logic [DW-1:0]         mem_data_in_1;
  logic [DW-1:0]         mem_data_in_2;
  logic                  mem_store_1;
  logic                  mem_store_2;
  logic [DW-1:0]         mem_data_out_1;
  logic [DW-1:0]         mem_data_out_2;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out_1, mem_data_out_2,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr_1, mem_addr_2, mem_addr_3, mem_addr_4,
    output mem_data_in_1, mem_data_in_2, mem_store_1, mem_store_2
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out_1, mem_data_out_2,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr_1, mem_addr_2, mem_addr_3, mem_addr_4,
    input  mem_data_in_1, mem_data_in_2, mem_store_1, mem_store_2
  );
endinterface

// File: rtl/qram_arbiter.sv
// Round-robin arbiter sharing the two qram ports among NUM_REQ requesters,
// issuing up to two accesses per cycle and routing read data back by tag.
module qram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  qram_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = IW + 1;

  logic [AW-1:0] addr  [NUM_REQ];
  logic [DW-1:0] wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr[g]  = bus.req_addr[g*AW +: AW];
    assign wdata[g] = bus.req_wdata[g*DW +: DW];
  end

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      next_ptr;
  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      cand;
  logic [SW-1:0]      sum;
  logic               gnt_x_vld;
  logic               gnt_y_vld;
  logic [IW-1:0]      gnt_x_idx;
  logic [IW-1:0]      gnt_y_idx;
  logic [NUM_REQ-1:0] ready;
  logic               we_x;
  logic               we_y;

  // Two reads of one address may share a cycle; anything involving a write may not.
  function automatic logic conflict(input logic [AW-1:0] a0, input logic we0,
                                    input logic [AW-1:0] a1, input logic we1);
    return (a0 == a1) && (we0 || we1);
  endfunction

  always_comb begin
    gnt_x_vld = 1'b0;
    gnt_y_vld = 1'b0;
    gnt_x_idx = '0;
    gnt_y_idx = '0;
    sum       = '0;
    cand      = '0;
    ready     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[IW-1:0];
      if (rst_n && bus.req_valid[cand]) begin
        if (!gnt_x_vld) begin
          gnt_x_vld = 1'b1;
          gnt_x_idx = cand;
        end else if (!gnt_y_vld &&
                     !conflict(addr[gnt_x_idx], bus.req_we[gnt_x_idx], addr[cand], bus.req_we[cand])) begin
          gnt_y_vld = 1'b1;
          gnt_y_idx = cand;
        end
      end
    end
    if (gnt_x_vld) ready[gnt_x_idx] = 1'b1;
    if (gnt_y_vld) ready[gnt_y_idx] = 1'b1;
    last_idx = gnt_y_vld ? gnt_y_idx : gnt_x_idx;
    next_ptr = (last_idx == IW'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
  end

  assign bus.req_ready = ready;
  assign we_x          = bus.req_we[gnt_x_idx];
  assign we_y          = bus.req_we[gnt_y_idx];

  always_ff @(posedge clk) begin
    if (!rst_n)         rr_ptr <= '0;
    else if (gnt_x_vld) rr_ptr <= next_ptr;
  end

  // Stage p0: qram port drive, one cycle per accepted access.
  logic [1:0]    rd_vld_p0;
  logic [IW-1:0] rd_idx_p0 [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_store_1   <= 1'b0;
      bus.mem_addr_1    <= '0;
      bus.mem_data_in_1 <= '0;
      bus.mem_addr_3    <= '0;
      bus.mem_store_2   <= 1'b0;
      bus.mem_addr_2    <= '0;
      bus.mem_data_in_2 <= '0;
      bus.mem_addr_4    <= '0;
      rd_vld_p0         <= '0;
    end else begin
      bus.mem_store_1   <= gnt_x_vld && we_x;
      bus.mem_addr_1    <= (gnt_x_vld && we_x)  ? addr[gnt_x_idx]  : '0;
      bus.mem_data_in_1 <= (gnt_x_vld && we_x)  ? wdata[gnt_x_idx] : '0;
      bus.mem_addr_3    <= (gnt_x_vld && !we_x) ? addr[gnt_x_idx]  : '0;
      bus.mem_store_2   <= gnt_y_vld && we_y;
      bus.mem_addr_2    <= (gnt_y_vld && we_y)  ? addr[gnt_y_idx]  : '0;
      bus.mem_data_in_2 <= (gnt_y_vld && we_y)  ? wdata[gnt_y_idx] : '0;
      bus.mem_addr_4    <= (gnt_y_vld && !we_y) ? addr[gnt_y_idx]  : '0;
      rd_vld_p0         <= {gnt_y_vld && !we_y, gnt_x_vld && !we_x};
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p0[0] <= gnt_x_idx;
    rd_idx_p0[1] <= gnt_y_idx;
  end

  // Stage p1: read tags wait out the qram latency, one entry per cycle of MEM_LAT.
  logic [1:0]    rd_vld_p1 [MEM_LAT];
  logic [IW-1:0] rd_idx_p1 [MEM_LAT][2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LAT; s++) rd_vld_p1[s] <= '0;
    end else begin
      rd_vld_p1[0] <= rd_vld_p0;
      for (int s = 1; s < MEM_LAT; s++) rd_vld_p1[s] <= rd_vld_p1[s-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p1[0] <= rd_idx_p0;
    for (int s = 1; s < MEM_LAT; s++) rd_idx_p1[s] <= rd_idx_p1[s-1];
  end

  // Stage p2: per-requester response registers; data holds between strobes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    logic          hit_x;
    logic          hit_y;
    logic          vld_p2;
    logic [DW-1:0] data_p2;

    assign hit_x = rd_vld_p1[MEM_LAT-1][0] && (rd_idx_p1[MEM_LAT-1][0] == IW'(g));
    assign hit_y = rd_vld_p1[MEM_LAT-1][1] && (rd_idx_p1[MEM_LAT-1][1] == IW'(g));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p2  <= 1'b0;
        data_p2 <= '0;
      end else begin
        vld_p2 <= hit_x || hit_y;
        if (hit_x)      data_p2 <= bus.mem_data_out_1;
        else if (hit_y) data_p2 <= bus.mem_data_out_2;
      end
    end

    assign bus.rsp_valid[g]            = vld_p2;
    assign bus.rsp_rdata[g*DW +: DW]   = data_p2;
  end
endmodule

// File: tb/tb_qram_arbiter.sv
// Directed bench for qram_arbiter with a write-first, one-cycle-latency qram model.
module tb_qram_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MEM_LAT = 1;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mem [256];

  qram_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  qram_arbiter #(.NUM_REQ(NUM_REQ), .MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_first(input logic [31:0] a);
    if (bus.mem_store_1 && bus.mem_addr_1 == a) return bus.mem_data_in_1;
    if (bus.mem_store_2 && bus.mem_addr_2 == a) return bus.mem_data_in_2;
    return mem[a[7:0]];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_store_1) mem[bus.mem_addr_1[7:0]] <= bus.mem_data_in_1;
    if (bus.mem_store_2) mem[bus.mem_addr_2[7:0]] <= bus.mem_data_in_2;
    bus.mem_data_out_1 <= rd_first(bus.mem_addr_3);
    bus.mem_data_out_2 <= rd_first(bus.mem_addr_4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  function automatic logic [31:0] rdata(input int i);
    return bus.rsp_rdata[i*32 +: 32];
  endfunction

  task automatic chk_idle_x(input string tag);
    chk({tag, "_store_1"},   32'(bus.mem_store_1), 32'h0);
    chk({tag, "_addr_1"},    bus.mem_addr_1,       32'h0);
    chk({tag, "_data_in_1"}, bus.mem_data_in_1,    32'h0);
    chk({tag, "_addr_3"},    bus.mem_addr_3,       32'h0);
  endtask

  task automatic chk_idle_y(input string tag);
    chk({tag, "_store_2"},   32'(bus.mem_store_2), 32'h0);
    chk({tag, "_addr_2"},    bus.mem_addr_2,       32'h0);
    chk({tag, "_data_in_2"}, bus.mem_data_in_2,    32'h0);
    chk({tag, "_addr_4"},    bus.mem_addr_4,       32'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state; a pending request must not be granted while in reset.
    set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1 chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    chk_idle_x("rst");
    chk_idle_y("rst");
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata0", rdata(0), 32'h0);

    // Test 1: write then read back 0x10 from requester 0.
    rst_n = 1'b1;
    #1 chk("t1_wr_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t1_wr_store_1", 32'(bus.mem_store_1), 32'h1);
    chk("t1_wr_addr_1", bus.mem_addr_1, 32'h10);
    chk("t1_wr_data_in_1", bus.mem_data_in_1, 32'hDEADBEEF);
    chk("t1_wr_addr_3", bus.mem_addr_3, 32'h0);
    chk("t1_wr_store_2", 32'(bus.mem_store_2), 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1 chk("t1_rd_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t1_rd_addr_3", bus.mem_addr_3, 32'h10);
    chk("t1_rd_store_1", 32'(bus.mem_store_1), 32'h0);
    chk("t1_rd_addr_1", bus.mem_addr_1, 32'h0);
    chk("t1_rsp_early0", 32'(bus.rsp_valid), 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t1_rsp_early1", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_rdata0", rdata(0), 32'hDEADBEEF);
    tick();
    chk("t1_rsp_strobe_end", 32'(bus.rsp_valid), 32'h0);
    chk("t1_rsp_rdata0_hold", rdata(0), 32'hDEADBEEF);

    // Test 2 setup: fill 0x0..0x3 with 0xA0..0xA3, leaving the pointer at 0.
    set_req(0, 1'b1, 1'b1, 32'h0, 32'hA0);
    set_req(1, 1'b1, 1'b1, 32'h1, 32'hA1);
    #1 chk("t2_wrA_ready", 32'(bus.req_ready), 32'h3);
    tick();
    chk("t2_wrA_store_1", 32'(bus.mem_store_1), 32'h1);
    chk("t2_wrA_addr_1", bus.mem_addr_1, 32'h1);
    chk("t2_wrA_data_in_1", bus.mem_data_in_1, 32'hA1);
    chk("t2_wrA_store_2", 32'(bus.mem_store_2), 32'h1);
    chk("t2_wrA_addr_2", bus.mem_addr_2, 32'h0);
    chk("t2_wrA_data_in_2", bus.mem_data_in_2, 32'hA0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b1, 1'b1, 32'h2, 32'hA2);
    set_req(3, 1'b1, 1'b1, 32'h3, 32'hA3);
    #1 chk("t2_wrB_ready", 32'(bus.req_ready), 32'hC);
    tick();
    chk("t2_wrB_addr_1", bus.mem_addr_1, 32'h2);
    chk("t2_wrB_addr_2", bus.mem_addr_2, 32'h3);
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);

    // Test 2: four continuous reads; grants alternate {0,1},{2,3}.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, (c < 4), 1'b0, 32'(i), 32'h0);
      #1 chk($sformatf("t2_ready_c%0d", c), 32'(bus.req_ready),
             (c >= 4) ? 32'h0 : ((c % 2 == 0) ? 32'h3 : 32'hC));
      tick();
      if (c < 2) begin
        chk($sformatf("t2_no_rsp_c%0d", c), 32'(bus.rsp_valid), 32'h0);
      end else begin
        chk($sformatf("t2_rsp_valid_c%0d", c), 32'(bus.rsp_valid),
            (c % 2 == 0) ? 32'h3 : 32'hC);
        for (int i = 0; i < 4; i++)
          if (((c % 2 == 0) && i < 2) || ((c % 2 == 1) && i >= 2))
            chk($sformatf("t2_rdata%0d_c%0d", i, c), rdata(i), 32'hA0 + 32'(i));
      end
    end

    // Test 3: two writes to one address serialise.
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h11111111);
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h22222222);
    #1 chk("t3_ready_first", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t3_first_store_1", 32'(bus.mem_store_1), 32'h1);
    chk("t3_first_addr_1", bus.mem_addr_1, 32'h20);
    chk("t3_first_data_in_1", bus.mem_data_in_1, 32'h11111111);
    chk("t3_first_store_2", 32'(bus.mem_store_2), 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("t3_ready_second", 32'(bus.req_ready), 32'h2);
    tick();
    chk("t3_second_store_1", 32'(bus.mem_store_1), 32'h1);
    chk("t3_second_data_in_1", bus.mem_data_in_1, 32'h22222222);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Test 4: seed 0x30, then two reads of it share one cycle.
    set_req(2, 1'b1, 1'b1, 32'h30, 32'h30303030);
    #1 chk("t4_seed_ready", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
    #1 chk("t4_ready", 32'(bus.req_ready), 32'h3);
    tick();
    chk("t4_addr_3", bus.mem_addr_3, 32'h30);
    chk("t4_addr_4", bus.mem_addr_4, 32'h30);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t4_rsp_early", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'h3);
    chk("t4_rdata0", rdata(0), 32'h30303030);
    chk("t4_rdata1", rdata(1), 32'h30303030);

    // Test 5: move the pointer to 1, then a lone requester 3 wraps it to 0.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1 chk("t5_pre_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h10, 32'h0);
    #1 chk("t5_ready", 32'(bus.req_ready), 32'h8);
    tick();
    chk("t5_addr_3", bus.mem_addr_3, 32'h10);
    chk("t5_store_1", 32'(bus.mem_store_1), 32'h0);
    chk_idle_y("t5_idle");
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h1, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h3, 32'h0);
    #1 chk("t5_ptr_wrap_ready", 32'(bus.req_ready), 32'h3);
    tick();
    chk("t5_pre_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t5_pre_rdata0", rdata(0), 32'hDEADBEEF);
    chk("t6_inflight_addr_3", bus.mem_addr_3, 32'h0);
    chk("t6_inflight_addr_4", bus.mem_addr_4, 32'h1);

    // Test 6: reset with reads in flight drops them.
    rst_n = 1'b0;
    #1 chk("t6_ready_in_reset", 32'(bus.req_ready), 32'h0);
    tick();
    chk_idle_x("t6_rst");
    chk_idle_y("t6_rst");
    chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t6_no_stale_rsp0", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t6_no_stale_rsp1", 32'(bus.rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
